// File: rtl/bloco_controle.sv
// Control FSM for the polynomial datapath: sequences A*x*x + B*x + C with a start/done handshake.
// Optional macro BC_PAUSA_EN adds a pausa input that freezes the sequence in place.
module bloco_controle #(
    parameter int OP_CYC = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inicio,
`ifdef BC_PAUSA_EN
    input  logic       pausa,
`endif
    output logic [1:0] M0,
    output logic [1:0] M1,
    output logic [1:0] M2,
    output logic       LX,
    output logic       LH,
    output logic       LS,
    output logic       H,
    output logic       ocupado,
    output logic       pronto
);

    typedef enum logic [2:0] {
        IDLE, LOADX, P1, P2, P3, P4, P5, DONE
    } estado_t;

    localparam logic [3:0] ULTIMO = 4'(OP_CYC - 1);

    estado_t    estado, proximo;
    logic [3:0] cont, cont_prox;
    logic       fim_fase;
    logic       congelado;

`ifdef BC_PAUSA_EN
    assign congelado = pausa && (estado != IDLE);
`else
    assign congelado = 1'b0;
`endif

    assign fim_fase = (cont == ULTIMO);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            estado <= IDLE;
            cont   <= 4'd0;
        end else if (!congelado) begin
            estado <= proximo;
            cont   <= cont_prox;
        end
    end

    // NOTE: every output is defaulted first so no path through the case leaves a latch behind.
    always_comb begin
        proximo   = estado;
        cont_prox = 4'd0;
        M0        = 2'b00;
        M1        = 2'b00;
        M2        = 2'b00;
        H         = 1'b0;
        LX        = 1'b0;
        LH        = 1'b0;
        LS        = 1'b0;
        pronto    = 1'b0;
        ocupado   = (estado != IDLE);

        // Phases share the counter; it restarts at zero whenever the phase advances.
        if (estado inside {P1, P2, P3, P4, P5}) begin
            cont_prox = fim_fase ? 4'd0 : cont + 4'd1;
        end

        unique case (estado)
            IDLE: begin
                if (inicio) proximo = LOADX;
            end
            LOADX: begin
                LX      = 1'b1;
                proximo = P1;
            end
            P1: begin
                M1 = 2'b01;
                H  = 1'b1;
                LH = fim_fase;
                if (fim_fase) proximo = P2;
            end
            P2: begin
                M0 = 2'b01;
                M2 = 2'b11;
                H  = 1'b1;
                LH = fim_fase;
                if (fim_fase) proximo = P3;
            end
            P3: begin
                M0 = 2'b10;
                H  = 1'b1;
                LS = fim_fase;
                if (fim_fase) proximo = P4;
            end
            P4: begin
                M1 = 2'b10;
                M2 = 2'b11;
                LH = fim_fase;
                if (fim_fase) proximo = P5;
            end
            P5: begin
                M0 = 2'b11;
                M2 = 2'b11;
                LS = fim_fase;
                if (fim_fase) proximo = DONE;
            end
            DONE: begin
                pronto  = 1'b1;
                proximo = IDLE;
            end
            default: proximo = IDLE;
        endcase

        // A frozen cycle must not load anything; selects keep their phase values.
        if (congelado) begin
            LX     = 1'b0;
            LH     = 1'b0;
            LS     = 1'b0;
            pronto = 1'b0;
        end
    end

endmodule

// File: tb/tb_bloco_controle.sv
// Directed bench for bloco_controle, including a behavioural datapath model to check the final result.
// Build with BC_PAUSA_EN defined to also exercise the pause feature.
module tb_bloco_controle;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, inicio0, inicio1;
`ifdef BC_PAUSA_EN
    logic pausa0, pausa1;
`endif
    logic [1:0] m0_0, m1_0, m2_0, m0_1, m1_1, m2_1;
    logic lx0, lh0, ls0, h0, oc0, pr0;
    logic lx1, lh1, ls1, h1, oc1, pr1;

    int total = 0;
    int bad   = 0;

    bloco_controle #(.OP_CYC(4)) u0 (
        .clk(clk), .rst(rst), .inicio(inicio0),
`ifdef BC_PAUSA_EN
        .pausa(pausa0),
`endif
        .M0(m0_0), .M1(m1_0), .M2(m2_0), .LX(lx0), .LH(lh0), .LS(ls0),
        .H(h0), .ocupado(oc0), .pronto(pr0)
    );

    bloco_controle #(.OP_CYC(2)) u1 (
        .clk(clk), .rst(rst), .inicio(inicio1),
`ifdef BC_PAUSA_EN
        .pausa(pausa1),
`endif
        .M0(m0_1), .M1(m1_1), .M2(m2_1), .LX(lx1), .LH(lh1), .LS(ls1),
        .H(h1), .ocupado(oc1), .pronto(pr1)
    );

    wire [11:0] obs0 = {m0_0, m1_0, m2_0, h0, lx0, lh0, ls0, oc0, pr0};
    wire [11:0] obs1 = {m0_1, m1_1, m2_1, h1, lx1, lh1, ls1, oc1, pr1};

    // Datapath model driven by u0.
    logic [15:0] a_c, b_c, c_c, x_in;
    logic [15:0] r0, r1, r2, k, op1, op2, res;

    always_comb begin
        case (m0_0)
            2'b00:   k = 16'd0;
            2'b01:   k = a_c;
            2'b10:   k = b_c;
            default: k = c_c;
        endcase
        case (m1_0)
            2'b00:   op1 = k;
            2'b01:   op1 = r0;
            2'b10:   op1 = r2;
            default: op1 = r1;
        endcase
        case (m2_0)
            2'b00:   op2 = r0;
            2'b01:   op2 = k;
            2'b10:   op2 = r2;
            default: op2 = r1;
        endcase
        res = h0 ? op1 * op2 : op1 + op2;
    end

    always @(posedge clk) begin
        if (!rst) begin
            r0 <= 16'd0;
            r1 <= 16'd0;
            r2 <= 16'd0;
        end else begin
            if (lx0) r0 <= x_in;
            if (lh0) r1 <= res;
            if (ls0) r2 <= res;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected {M0,M1,M2,H,LX,LH,LS,ocupado,pronto} in cycle cyc after acceptance (LOADX = 1).
    function automatic logic [11:0] exp_out(input int cyc, input int opc);
        int       last;
        int       p;
        logic     stb;
        logic [6:0] sel;
        logic     lh, ls;
        last = 1 + 5 * opc;
        if (cyc == 1) return 12'b0000_0001_0010;
        if (cyc == last + 1) return 12'b0000_0000_0011;
        if (cyc < 2 || cyc > last) return 12'b0;
        p   = (cyc - 2) / opc;
        stb = (((cyc - 2) % opc) == opc - 1);
        lh  = 1'b0;
        ls  = 1'b0;
        case (p)
            0:       begin sel = 7'b00_01_00_1; lh = stb; end
            1:       begin sel = 7'b01_00_11_1; lh = stb; end
            2:       begin sel = 7'b10_00_00_1; ls = stb; end
            3:       begin sel = 7'b00_10_11_0; lh = stb; end
            default: begin sel = 7'b11_00_11_0; ls = stb; end
        endcase
        return {sel, 1'b0, lh, ls, 1'b1, 1'b0};
    endfunction

    task automatic run0(input int pause_at, input int pause_len, input int bump_at,
                        input logic [15:0] want);
        logic [11:0] e;
        inicio0 = 1'b1;
        for (int cyc = 1; cyc <= 23 + pause_len; cyc++) begin
            @(posedge clk); #1;
            inicio0 = (cyc == bump_at);
`ifdef BC_PAUSA_EN
            pausa0 = (pause_len > 0) && (cyc >= pause_at) && (cyc < pause_at + pause_len);
`endif
            #1;
            if (pause_len == 0 || cyc < pause_at)
                e = exp_out(cyc, 4);
            else if (cyc < pause_at + pause_len)
                e = exp_out(pause_at, 4) & 12'b1111_1110_0010;
            else
                e = exp_out(cyc - pause_len, 4);
            check($sformatf("u0 cyc%0d", cyc), obs0, e);
            if (cyc == 22 + pause_len) check("result r2", r2, want);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; inicio0 = 1'b0; inicio1 = 1'b0;
`ifdef BC_PAUSA_EN
        pausa0 = 1'b0; pausa1 = 1'b0;
`endif
        a_c = 16'd2; b_c = 16'd2; c_c = 16'd1; x_in = 16'd2;

        // Reset, then idle.
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #2;
            check("reset u0", obs0, 12'b0);
        end
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #2;
            check($sformatf("idle u0 %0d", i), obs0, 12'b0);
            check($sformatf("idle u1 %0d", i), obs1, 12'b0);
        end

        // Full run with a second inicio while busy: result 13, pronto at 22.
        run0(0, 0, 8, 16'd13);

        // Different coefficients: 1*9 + 3*3 + 5 = 23.
        a_c = 16'd1; b_c = 16'd3; c_c = 16'd5; x_in = 16'd3;
        run0(0, 0, 0, 16'd23);

        // Reset in P3 with counter = 2 (cycle 12), then a clean rerun.
        a_c = 16'd2; b_c = 16'd2; c_c = 16'd1; x_in = 16'd2;
        inicio0 = 1'b1;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(posedge clk); #1;
            inicio0 = 1'b0;
        end
        #1;
        check("mid-run P3 cnt2", obs0, exp_out(12, 4));
        rst = 1'b0;
        @(posedge clk); #2;
        check("mid-run reset", obs0, 12'b0);
        rst = 1'b1;
        @(posedge clk); #2;
        check("after reset idle", obs0, 12'b0);
        run0(0, 0, 0, 16'd13);

        // OP_CYC=2 with inicio held: pronto at 12, IDLE at 13, next LOADX at 14.
        inicio1 = 1'b1;
        for (int cyc = 1; cyc <= 14; cyc++) begin
            @(posedge clk); #2;
            check($sformatf("u1 cyc%0d", cyc), obs1, (cyc == 14) ? exp_out(1, 2) : exp_out(cyc, 2));
        end
        inicio1 = 1'b0;
        for (int i = 0; i < 12; i++) @(posedge clk);
        #2;
        check("u1 back idle", obs1, 12'b0);

`ifdef BC_PAUSA_EN
        // Three-cycle pause in P2: everything slips by exactly three cycles.
        run0(7, 3, 0, 16'd13);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bloco_controle.md
Name: bloco_controle

Overview:
- Control FSM (bloco de controle) directly upstream of the polynomial datapath.
- Drives every datapath select and strobe (M0, M1, M2, LX, LH, LS, H) so the datapath evaluates A*x*x + B*x + C.
- The result lands in the datapath's R2 register and appears on its Pronto output.
- Adds a start/done handshake and fixes the operation order in hardware, replacing hand-driven stimulus.

Parameters:
- OP_CYC, default 4: cycles per arithmetic phase; legal range 2..15. The load strobe fires on the last cycle of each phase.

Ports:
- clk  input  1  system clock; rising edge.
- rst  input  1  synchronous, active-low reset.
- inicio  input  1  start request; sampled only in IDLE.
- M0  output  2  constant select: 00=0, 01=A, 10=B, 11=C.
- M1  output  2  ULA operand-1 select: 00=M0 path, 01=R0(x), 10=R2, 11=R1.
- M2  output  2  ULA operand-2 select: 00=R0(x), 01=M0 path, 10=R2, 11=R1.
- LX  output  1  load strobe for R0 (x).
- LH  output  1  load strobe for R1.
- LS  output  1  load strobe for R2 (result).
- H  output  1  ULA operation: 1=multiply, 0=add.
- ocupado  output  1  high from the cycle after inicio is accepted through the DONE cycle.
- pronto  output  1  one-cycle pulse; R2 holds the valid result.

Behaviour:
- Reset: rst low at a rising edge forces state IDLE, phase counter 0, and all outputs 0 (M0=M1=M2=00, LX=LH=LS=H=0, ocupado=0, pronto=0) from that edge onward. This holds in every state, including mid-phase.
- States: IDLE, LOADX, P1, P2, P3, P4, P5, DONE.
- IDLE: all outputs 0. If inicio=1, next state is LOADX.
- LOADX: 1 cycle; LX=1, all selects 00, H=0. Next state is P1.
- Every phase Pn lasts exactly OP_CYC cycles, counted by a 4-bit counter cleared on phase entry.
  - M0, M1, M2 and H are held constant for the whole phase.
  - The load strobe is 1 only when counter = OP_CYC-1; the phase then advances.
- Phase encodings (M0, M1, M2, H, strobe):
  - P1: 00, 01, 00, 1, LH. R1 = x*x.
  - P2: 01, 00, 11, 1, LH. R1 = A*R1.
  - P3: 10, 00, 00, 1, LS. R2 = B*x.
  - P4: 00, 10, 11, 0, LH. R1 = R2+R1.
  - P5: 11, 00, 11, 0, LS. R2 = C+R1.
- DONE: 1 cycle; pronto=1, selects 00, strobes 0. Next state is IDLE.
- Latency: inicio sampled at edge k gives pronto high in cycle k+2+5*OP_CYC. With OP_CYC=4 that is 22 cycles.
- inicio is ignored outside IDLE; no restart mid-run.
- inicio held high continuously: a new run starts after exactly one IDLE cycle following DONE.
- At most one of LX, LH, LS is high in any cycle.
- ocupado=1 in LOADX through DONE inclusive.
- Counter wrap is impossible; the counter is compared against OP_CYC-1 before it can exceed it.

Optional Feature:
- Macro: BC_PAUSA_EN.
- Defined:
  - Adds input port pausa (1 bit) after inicio.
  - While pausa=1 in LOADX, P1..P5 or DONE: state and counter freeze; LX, LH, LS and pronto are forced 0; M0, M1, M2 and H hold their current phase values.
  - Releasing pausa resumes in the exact same cycle position.
  - pausa has no effect in IDLE.
  - rst overrides pausa.
- Undefined: no pausa port; behaviour as above.

Test Plan:
- Reset then idle: rst=0 for 2 cycles, inicio=0 -> all outputs 0 and ocupado=0 for 10 cycles.
- Full run, OP_CYC=4, wired to the datapath with A=2, B=2, C=1, x=2: pulse inicio -> LX at cycle 1; LH at cycles 5, 9, 17; LS at cycles 13, 21; pronto at cycle 22; Pronto=13.
- Select trace: same run -> per-phase (M0, M1, M2, H) match the P1..P5 table on every cycle of each phase, and exactly one strobe per phase.
- Busy ignore: inicio pulsed again at cycle 8 -> no effect; pronto still at 22; state returns to IDLE at 23.
- Reset mid-run: rst=0 during P3 counter=2 -> outputs 0 next edge; a new inicio gives the correct result 13 after 22 cycles.
- OP_CYC=2 with inicio held high -> pronto at 12, one IDLE cycle, second run's LX at 14. With BC_PAUSA_EN and pausa=1 for 3 cycles mid-P2 -> pronto delayed by exactly 3 cycles and no strobe during the pause.
